// File: rtl/butterfly_r2_pipe.sv
// Radix-2 FFT butterfly with two pipeline stages and valid/ready flow control.
//   out1 = in1 + in2, out2 = in1 - in2 on complex operands.
// Stage 1 registers the BIT_WIDTH+1 sums/differences together with the
// per-transaction scale bit. Stage 2 applies optional /2 scaling with rounding,
// reduces to BIT_WIDTH, registers the outputs and detects overflow.
// Optional feature macro BFLY_SAT_EN: when defined, overflowing words clamp
// to the signed range; when undefined, they wrap to the low BIT_WIDTH bits.
// Overflow detection, the sticky flag and the event counter are identical in
// both builds.

module butterfly_r2_pipe #(
  parameter int BIT_WIDTH = 16,
  parameter int ROUND     = 1,
  parameter int CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BIT_WIDTH-1:0] xin1,
  input  logic [BIT_WIDTH-1:0] yin1,
  input  logic [BIT_WIDTH-1:0] xin2,
  input  logic [BIT_WIDTH-1:0] yin2,
  input  logic                 scale,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BIT_WIDTH-1:0] xout1,
  output logic [BIT_WIDTH-1:0] yout1,
  output logic [BIT_WIDTH-1:0] xout2,
  output logic [BIT_WIDTH-1:0] yout2,
  input  logic                 clr_ovf,
  output logic                 ovf_flag,
  output logic [CNT_W-1:0]     ovf_cnt
);

  // Stage-1 word: one guard bit so the full sum/difference is exact.
  localparam int SW = BIT_WIDTH + 1;
  // Rounding word: one more bit so full + ROUND cannot wrap before the shift.
  localparam int RW = BIT_WIDTH + 2;

  localparam logic [BIT_WIDTH-1:0] MAX_W = {1'b0, {(BIT_WIDTH-1){1'b1}}};
  localparam logic [BIT_WIDTH-1:0] MIN_W = {1'b1, {(BIT_WIDTH-1){1'b0}}};

  // Scale/round one full-precision word and reduce it to BIT_WIDTH.
  // Returns {overflow, word}.
  function automatic logic [BIT_WIDTH:0] reduce_word(input logic [SW-1:0] full,
                                                     input logic          sc);
    logic [RW-1:0]        ext;
    logic [RW-1:0]        rsum;
    logic [RW-1:0]        r;
    logic                 ovf;
    logic [BIT_WIDTH-1:0] word;
    ext  = {full[SW-1], full};
    rsum = ext + RW'(ROUND);
    // Arithmetic shift right by one of the rounded value.
    r    = sc ? {rsum[RW-1], rsum[RW-1:1]} : ext;
    // In range only when the bits above the BIT_WIDTH sign bit are all copies of it.
    ovf  = (r[RW-1:BIT_WIDTH-1] != '0) && (r[RW-1:BIT_WIDTH-1] != '1);
`ifdef BFLY_SAT_EN
    if (ovf) word = r[RW-1] ? MIN_W : MAX_W;
    else     word = r[BIT_WIDTH-1:0];
`else
    word = r[BIT_WIDTH-1:0];
`endif
    return {ovf, word};
  endfunction

  // Stage state
  logic          s1_valid_q;
  logic          s1_scale_q;
  logic [SW-1:0] s1_xs_q, s1_ys_q, s1_xd_q, s1_yd_q;
  logic [SW-1:0] s1_xs_d, s1_ys_d, s1_xd_d, s1_yd_d;

  logic                 out_valid_q;
  logic [BIT_WIDTH-1:0] xout1_q, yout1_q, xout2_q, yout2_q;
  logic [BIT_WIDTH:0]   xs_r, ys_r, xd_r, yd_r;
  logic                 pair_ovf;

  logic             ovf_flag_q, ovf_flag_d;
  logic [CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;

  logic en1, en2;

  // Pipeline advance: a stage moves when it is empty or its successor moves.
  assign en2      = !out_valid_q || out_ready;
  assign en1      = !s1_valid_q || en2;
  assign in_ready = en1;

  // Exact sign-extended sums and differences of the incoming pair.
  assign s1_xs_d = {xin1[BIT_WIDTH-1], xin1} + {xin2[BIT_WIDTH-1], xin2};
  assign s1_ys_d = {yin1[BIT_WIDTH-1], yin1} + {yin2[BIT_WIDTH-1], yin2};
  assign s1_xd_d = {xin1[BIT_WIDTH-1], xin1} - {xin2[BIT_WIDTH-1], xin2};
  assign s1_yd_d = {yin1[BIT_WIDTH-1], yin1} - {yin2[BIT_WIDTH-1], yin2};

  // Stage-2 reduction of the four stage-1 words.
  assign xs_r     = reduce_word(s1_xs_q, s1_scale_q);
  assign ys_r     = reduce_word(s1_ys_q, s1_scale_q);
  assign xd_r     = reduce_word(s1_xd_q, s1_scale_q);
  assign yd_r     = reduce_word(s1_yd_q, s1_scale_q);
  assign pair_ovf = xs_r[BIT_WIDTH] | ys_r[BIT_WIDTH] | xd_r[BIT_WIDTH] | yd_r[BIT_WIDTH];

  // Stage 1 register: capture the sums/diffs and scale bit on an input transfer.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: data registers are reset too, so a reset leaves no stale words anywhere.
      s1_valid_q <= 1'b0;
      s1_scale_q <= 1'b0;
      s1_xs_q    <= '0;
      s1_ys_q    <= '0;
      s1_xd_q    <= '0;
      s1_yd_q    <= '0;
    end else if (en1) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_scale_q <= scale;
        s1_xs_q    <= s1_xs_d;
        s1_ys_q    <= s1_ys_d;
        s1_xd_q    <= s1_xd_d;
        s1_yd_q    <= s1_yd_d;
      end
    end
  end

  // Stage 2 register: load reduced words when stage 1 holds a pair and S2 may advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      xout1_q     <= '0;
      yout1_q     <= '0;
      xout2_q     <= '0;
      yout2_q     <= '0;
    end else if (en2) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        xout1_q <= xs_r[BIT_WIDTH-1:0];
        yout1_q <= ys_r[BIT_WIDTH-1:0];
        xout2_q <= xd_r[BIT_WIDTH-1:0];
        yout2_q <= yd_r[BIT_WIDTH-1:0];
      end
    end
  end

  // Overflow flag/counter next state; an overflowing load wins over a clear.
  always_comb begin
    // NOTE: hold values assigned first so no path leaves a variable unassigned (no latch).
    ovf_flag_d = ovf_flag_q;
    ovf_cnt_d  = ovf_cnt_q;
    if (en2 && s1_valid_q && pair_ovf) begin
      ovf_flag_d = 1'b1;
      if (clr_ovf)               ovf_cnt_d = CNT_W'(1);
      else if (ovf_cnt_q != '1)  ovf_cnt_d = ovf_cnt_q + CNT_W'(1);
    end else if (clr_ovf) begin
      ovf_flag_d = 1'b0;
      ovf_cnt_d  = '0;
    end
  end

  // Overflow flag/counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_flag_q <= 1'b0;
      ovf_cnt_q  <= '0;
    end else begin
      ovf_flag_q <= ovf_flag_d;
      ovf_cnt_q  <= ovf_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign xout1     = xout1_q;
  assign yout1     = yout1_q;
  assign xout2     = xout2_q;
  assign yout2     = yout2_q;
  assign ovf_flag  = ovf_flag_q;
  assign ovf_cnt   = ovf_cnt_q;

endmodule

// File: tb/tb_butterfly_r2_pipe.sv
// Testbench for butterfly_r2_pipe (default parameters).
// Expected results come from an integer-arithmetic model of the butterfly;
// a negedge monitor records accepted inputs (as model results) and emitted
// outputs, and each test task compares what it needs.

module tb_butterfly_r2_pipe;

  localparam int BW    = 16;
  localparam int ROUND = 1;
  localparam int CNT_W = 8;
  localparam int MAXV  = 2**(BW-1) - 1;
  localparam int MINV  = -(2**(BW-1));

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [BW-1:0] xin1 = '0, yin1 = '0, xin2 = '0, yin2 = '0;
  logic          scale = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [BW-1:0] xout1, yout1, xout2, yout2;
  logic          clr_ovf = 1'b0;
  logic          ovf_flag;
  logic [CNT_W-1:0] ovf_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [BW-1:0] x1, y1, x2, y2;
    bit            ovf;
  } res_t;

  res_t exp_q[$];
  res_t got_q[$];
  res_t mon_g;

  butterfly_r2_pipe #(.BIT_WIDTH(BW), .ROUND(ROUND), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .xin1(xin1), .yin1(yin1), .xin2(xin2), .yin2(yin2), .scale(scale),
    .out_valid(out_valid), .out_ready(out_ready),
    .xout1(xout1), .yout1(yout1), .xout2(xout2), .yout2(yout2),
    .clr_ovf(clr_ovf), .ovf_flag(ovf_flag), .ovf_cnt(ovf_cnt)
  );

  always #5 clk = ~clk;

  // Reference: exact integer sum/diff, optional (v+ROUND)/2 floor, then range check.
  function automatic res_t model(input logic [BW-1:0] a, b, c, d, input bit sc);
    int   ia, ib, ic, id, r;
    int   f[4];
    logic [BW-1:0] w[4];
    res_t res;
    ia = $signed(a); ib = $signed(b); ic = $signed(c); id = $signed(d);
    f[0] = ia + ic; f[1] = ib + id; f[2] = ia - ic; f[3] = ib - id;
    res.ovf = 1'b0;
    for (int i = 0; i < 4; i++) begin
      r = sc ? ((f[i] + ROUND) >>> 1) : f[i];
      if (r > MAXV || r < MINV) begin
        res.ovf = 1'b1;
`ifdef BFLY_SAT_EN
        r = (r > 0) ? MAXV : MINV;
`endif
      end
      w[i] = r[BW-1:0];
    end
    res.x1 = w[0]; res.y1 = w[1]; res.x2 = w[2]; res.y2 = w[3];
    return res;
  endfunction

  // Monitor: values at the negedge are those the next rising edge will act on.
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready) exp_q.push_back(model(xin1, yin1, xin2, yin2, scale));
      if (out_valid && out_ready) begin
        mon_g.x1 = xout1; mon_g.y1 = yout1; mon_g.x2 = xout2; mon_g.y2 = yout2;
        mon_g.ovf = 1'b0;
        got_q.push_back(mon_g);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int a, b, c, d, input bit sc);
    xin1 = BW'(a); yin1 = BW'(b); xin2 = BW'(c); yin2 = BW'(d); scale = sc;
  endtask

  function automatic logic [BW-1:0] rand_word();
    case ($urandom_range(0, 5))
      0:       return BW'(MAXV);
      1:       return BW'(MINV);
      default: return BW'($urandom);
    endcase
  endfunction

  // Present one pair for one cycle; with out_ready=1 its result is on the outputs afterwards.
  task automatic send_one(input int a, b, c, d, input bit sc);
    drive(a, b, c, d, sc);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if ({xout1, yout1, xout2, yout2} !== '0) begin n_bad++; $display("FAIL reset_outputs: got %h want 0", {xout1, yout1, xout2, yout2}); end
    n_cmp++; if (ovf_flag !== 1'b0 || ovf_cnt !== '0) begin n_bad++; $display("FAIL reset_ovf: got flag %b cnt %0d want 0/0", ovf_flag, ovf_cnt); end
    #2 rst_n = 1'b1;
    tick();
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    drive(100, -50, 30, 20, 1'b0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL basic_latency1: out_valid got %b want 0", out_valid); end
    tick();
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL basic_latency2: out_valid got %b want 1", out_valid); end
    n_cmp++;
    if ($signed(xout1) !== 130 || $signed(yout1) !== -30 || $signed(xout2) !== 70 || $signed(yout2) !== -70) begin
      n_bad++;
      $display("FAIL basic_data: got %0d %0d %0d %0d want 130 -30 70 -70",
               $signed(xout1), $signed(yout1), $signed(xout2), $signed(yout2));
    end
    n_cmp++; if (ovf_flag !== 1'b0) begin n_bad++; $display("FAIL basic_ovf: got %b want 0", ovf_flag); end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL basic_no_dup: out_valid got %b want 0", out_valid); end
  endtask

  task automatic test_scale_round();
    send_one(3, -3, 0, 0, 1'b1);
    n_cmp++;
    if (out_valid !== 1'b1 || $signed(xout1) !== 2 || $signed(yout1) !== -1 || $signed(xout2) !== 2 || $signed(yout2) !== -1) begin
      n_bad++;
      $display("FAIL scale_round: got v=%b %0d %0d %0d %0d want v=1 2 -1 2 -1", out_valid,
               $signed(xout1), $signed(yout1), $signed(xout2), $signed(yout2));
    end
  endtask

  task automatic test_overflow();
    int ex;
`ifdef BFLY_SAT_EN
    ex = MAXV;
`else
    ex = MINV;
`endif
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
    send_one(MAXV, 0, 1, 0, 1'b0);
    n_cmp++; if ($signed(xout1) !== ex || $signed(xout2) !== MAXV - 1) begin n_bad++; $display("FAIL ovf_add: got %0d %0d want %0d %0d", $signed(xout1), $signed(xout2), ex, MAXV - 1); end
    n_cmp++; if (ovf_flag !== 1'b1 || ovf_cnt !== 8'd1) begin n_bad++; $display("FAIL ovf_add_flag: got flag %b cnt %0d want 1/1", ovf_flag, ovf_cnt); end
    tick();
    send_one(MAXV, 0, MINV, 0, 1'b1);
    n_cmp++; if ($signed(xout1) !== 0 || $signed(xout2) !== ex) begin n_bad++; $display("FAIL ovf_round: got %0d %0d want 0 %0d", $signed(xout1), $signed(xout2), ex); end
    n_cmp++; if (ovf_cnt !== 8'd2) begin n_bad++; $display("FAIL ovf_round_cnt: got %0d want 2", ovf_cnt); end
  endtask

  task automatic test_flag_control();
    out_ready = 1'b1;
    // Overflowing pair enters S1; clear coincides with its S2 load.
    drive(MAXV, 0, 1, 0, 1'b0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    clr_ovf  = 1'b1;
    tick();
    clr_ovf  = 1'b0;
    n_cmp++; if (ovf_flag !== 1'b1 || ovf_cnt !== 8'd1) begin n_bad++; $display("FAIL clr_vs_load: got flag %b cnt %0d want 1/1", ovf_flag, ovf_cnt); end
    in_valid = 1'b1;
    repeat (300) tick();
    in_valid = 1'b0;
    repeat (3) tick();
    n_cmp++; if (ovf_cnt !== 8'd255 || ovf_flag !== 1'b1) begin n_bad++; $display("FAIL cnt_saturate: got flag %b cnt %0d want 1/255", ovf_flag, ovf_cnt); end
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
    n_cmp++; if (ovf_flag !== 1'b0 || ovf_cnt !== '0) begin n_bad++; $display("FAIL clr_alone: got flag %b cnt %0d want 0/0", ovf_flag, ovf_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [BW-1:0] px1[8], py1[8], px2[8], py2[8];
    bit            psc[8];
    res_t          e;
    logic [4*BW-1:0] snap;
    int i, c;
    bit acc;
    for (int k = 0; k < 8; k++) begin
      px1[k] = rand_word(); py1[k] = rand_word(); px2[k] = rand_word(); py2[k] = rand_word();
      psc[k] = 1'($urandom);
    end
    exp_q.delete(); got_q.delete();
    i = 0; c = 0; snap = '0;
    while (i < 8 && c < 40) begin
      out_ready = !(c >= 4 && c <= 6);
      in_valid  = 1'b1;
      xin1 = px1[i]; yin1 = py1[i]; xin2 = px2[i]; yin2 = py2[i]; scale = psc[i];
      #2;
      acc = in_ready;
      if (c >= 4 && c <= 6) begin
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_in_ready c=%0d: got %b want 0", c, in_ready); end
        if (c == 4) snap = {xout1, yout1, xout2, yout2};
        else begin
          n_cmp++;
          if (out_valid !== 1'b1 || {xout1, yout1, xout2, yout2} !== snap) begin
            n_bad++; $display("FAIL b2b_stall_stable c=%0d: got v=%b %h want v=1 %h", c, out_valid, {xout1, yout1, xout2, yout2}, snap);
          end
        end
      end
      tick();
      if (acc) i++;
      c++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) tick();
    n_cmp++; if (got_q.size() !== 8) begin n_bad++; $display("FAIL b2b_count: got %0d outputs want 8", got_q.size()); end
    for (int k = 0; k < 8 && k < got_q.size(); k++) begin
      e = model(px1[k], py1[k], px2[k], py2[k], psc[k]);
      n_cmp++;
      if ({got_q[k].x1, got_q[k].y1, got_q[k].x2, got_q[k].y2} !== {e.x1, e.y1, e.x2, e.y2}) begin
        n_bad++; $display("FAIL b2b_data[%0d]: got %h want %h", k,
                          {got_q[k].x1, got_q[k].y1, got_q[k].x2, got_q[k].y2}, {e.x1, e.y1, e.x2, e.y2});
      end
    end
  endtask

  task automatic test_random();
    bit acc;
    int nov, bad_here, want_cnt;
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
    exp_q.delete(); got_q.delete();
    acc = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (!in_valid || acc) begin
        xin1 = rand_word(); yin1 = rand_word(); xin2 = rand_word(); yin2 = rand_word();
        scale = 1'($urandom);
        in_valid = ($urandom_range(0, 3) != 0);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      #2;
      acc = in_valid && in_ready;
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) tick();
    n_cmp++; if (got_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL rand_count: got %0d outputs want %0d", got_q.size(), exp_q.size()); end
    nov = 0; bad_here = 0;
    foreach (exp_q[k]) begin
      if (exp_q[k].ovf) nov++;
      if (k < got_q.size() && bad_here < 5) begin
        n_cmp++;
        if ({got_q[k].x1, got_q[k].y1, got_q[k].x2, got_q[k].y2} !== {exp_q[k].x1, exp_q[k].y1, exp_q[k].x2, exp_q[k].y2}) begin
          n_bad++; bad_here++;
          $display("FAIL rand_data[%0d]: got %h want %h", k, {got_q[k].x1, got_q[k].y1, got_q[k].x2, got_q[k].y2},
                   {exp_q[k].x1, exp_q[k].y1, exp_q[k].x2, exp_q[k].y2});
        end
      end
    end
    want_cnt = (nov > 255) ? 255 : nov;
    n_cmp++; if (ovf_cnt !== CNT_W'(want_cnt) || ovf_flag !== (nov > 0)) begin n_bad++; $display("FAIL rand_ovf: got flag %b cnt %0d want %b/%0d", ovf_flag, ovf_cnt, nov > 0, want_cnt); end
  endtask

  task automatic test_reset_mid();
    res_t e;
    out_ready = 1'b0;
    drive(MAXV, 5, 1, 6, 1'b0);
    in_valid = 1'b1;
    tick();
    drive(11, 12, 13, 14, 1'b0);
    tick();
    in_valid = 1'b0;
    tick();
    n_cmp++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin n_bad++; $display("FAIL rmid_full: got v=%b rdy=%b want 1/0", out_valid, in_ready); end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || {xout1, yout1, xout2, yout2} !== '0 || ovf_flag !== 1'b0 || ovf_cnt !== '0) begin
      n_bad++; $display("FAIL rmid_flush: got v=%b out=%h flag=%b cnt=%0d want all 0", out_valid, {xout1, yout1, xout2, yout2}, ovf_flag, ovf_cnt);
    end
    #1 rst_n = 1'b1;
    #2;
    n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_release: got rdy=%b v=%b want 1/0", in_ready, out_valid); end
    exp_q.delete(); got_q.delete();
    @(posedge clk); #1;
    out_ready = 1'b1;
    drive(-1234, 777, 4321, -99, 1'b1);
    e = model(xin1, yin1, xin2, yin2, scale);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_lat1: out_valid got %b want 0", out_valid); end
    tick();
    n_cmp++;
    if (out_valid !== 1'b1 || {xout1, yout1, xout2, yout2} !== {e.x1, e.y1, e.x2, e.y2}) begin
      n_bad++; $display("FAIL rmid_lat2: got v=%b %h want v=1 %h", out_valid, {xout1, yout1, xout2, yout2}, {e.x1, e.y1, e.x2, e.y2});
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_scale_round();
    test_overflow();
    test_flag_control();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
